// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - game-flow controller bus: graph/button inputs and text-side status outputs
interface pong_game_ctrl_if #(
  parameter int LIVES_W = 3,
  parameter int DIGITS  = 2,
  parameter int BTN_W   = 2
);
  logic                frame_tick;
  logic [BTN_W-1:0]    btn;
  logic                pause_btn;
  logic                hit;
  logic                miss;
  logic                gra_still;
  logic [2:0]          state;
  logic [LIVES_W-1:0]  lives;
  logic [4*DIGITS-1:0] score;
  logic [4*DIGITS-1:0] hiscore;

  modport master (
    output frame_tick, btn, pause_btn, hit, miss,
    input  gra_still, state, lives, score, hiscore
  );

  modport slave (
    input  frame_tick, btn, pause_btn, hit, miss,
    output gra_still, state, lives, score, hiscore
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game-flow FSMD: frame timer, BCD score, lives, pause (optional PONG_HISCORE_EN)
module pong_game_ctrl #(
  parameter int LIVES       = 3,
  parameter int LIVES_W     = 3,
  parameter int DIGITS      = 2,
  parameter int WAIT_FRAMES = 120,
  parameter int TMR_W       = 8,
  parameter int BTN_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  pong_game_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    NEWGAME = 3'd0,
    PLAY    = 3'd1,
    NEWBALL = 3'd2,
    OVER    = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [TMR_W-1:0]   TMR_INIT   = TMR_W'(WAIT_FRAMES);

  state_t              state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [4*DIGITS-1:0] score_q, score_d, score_inc;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                timer_load;
  logic                timer_up;
  logic                pause_q;
  logic                pause_edge;

  // Decimal ripple increment; an all-nines score is held rather than wrapped to zero.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    logic                all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return all9 ? v : r;
  endfunction

  assign score_inc  = bcd_inc(score_q);
  assign pause_edge = bus.pause_btn & ~pause_q;
  assign timer_up   = (timer_q == '0);

  // Timer: a load wins over a same-cycle frame_tick; counting stops at zero and while paused.
  assign timer_d = timer_load ? TMR_INIT :
                   (bus.frame_tick && !timer_up && state_q != PAUSE) ? timer_q - TMR_W'(1) :
                   timer_q;

  // Next-state and datapath updates; miss outranks a same-cycle pause request.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    timer_load = 1'b0;
    case (state_q)
      NEWGAME: begin
        lives_d = LIVES_INIT;
        score_d = '0;
        if (|bus.btn) state_d = PLAY;
      end
      PLAY: begin
        if (bus.hit) score_d = score_inc;
        if (bus.miss) begin
          if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
          timer_load = 1'b1;
          state_d    = (lives_q <= LIVES_W'(1)) ? OVER : NEWBALL;
        end else if (pause_edge) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_edge) state_d = PLAY;
      end
      NEWBALL: begin
        if (timer_up && |bus.btn) state_d = PLAY;
      end
      OVER: begin
        if (timer_up) begin
          state_d = NEWGAME;
          lives_d = LIVES_INIT;
          score_d = '0;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NEWGAME;
    else       state_q <= state_d;
  end

  // Datapath registers and the pause-button delay used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lives_q <= LIVES_INIT;
      score_q <= '0;
      timer_q <= '0;
      pause_q <= 1'b0;
    end else begin
      lives_q <= lives_d;
      score_q <= score_d;
      timer_q <= timer_d;
      pause_q <= bus.pause_btn;
    end
  end

`ifdef PONG_HISCORE_EN
  logic [4*DIGITS-1:0] hiscore_q;

  // Capture the final score on game over; valid BCD compares correctly as an unsigned vector (MSD first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiscore_q <= '0;
    end else if (state_q == PLAY && state_d == OVER && score_d > hiscore_q) begin
      hiscore_q <= score_d;
    end
  end

  assign bus.hiscore = hiscore_q;
`else
  assign bus.hiscore = '0;
`endif

  assign bus.state     = state_q;
  assign bus.gra_still = (state_q != PLAY);
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] hi_exp;

  pong_game_ctrl_if #(.LIVES_W(3), .DIGITS(2), .BTN_W(2)) bus ();

  pong_game_ctrl #(
    .LIVES(3), .LIVES_W(3), .DIGITS(2), .WAIT_FRAMES(120), .TMR_W(8), .BTN_W(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
`ifdef PONG_HISCORE_EN
    hi_exp = 8'h99;
`else
    hi_exp = 8'h00;
`endif
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.btn        = 2'b00;
    bus.pause_btn  = 1'b0;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    repeat (2) step();
    check("rst_state", bus.state, 3'd0);
    check("rst_lives", bus.lives, 3'd3);
    check("rst_score", bus.score, 8'h00);
    check("rst_still", bus.gra_still, 1'b1);
    check("rst_hi", bus.hiscore, 8'h00);
    reset = 1'b0;
    step();

    // T1: start game
    bus.btn = 2'b01; step(); bus.btn = 2'b00;
    check("t1_state", bus.state, 3'd1);
    check("t1_lives", bus.lives, 3'd3);
    check("t1_score", bus.score, 8'h00);
    check("t1_still", bus.gra_still, 1'b0);

    // T2: three hits, miss, timer gate with button held
    for (int i = 0; i < 3; i++) begin
      bus.hit = 1'b1; step(); bus.hit = 1'b0; step();
    end
    check("t2_score", bus.score, 8'h03);
    bus.btn = 2'b10; bus.miss = 1'b1; step(); bus.miss = 1'b0;
    check("t2_lives", bus.lives, 3'd2);
    check("t2_state", bus.state, 3'd2);
    check("t2_still", bus.gra_still, 1'b1);
    ticks(119);
    repeat (3) step();
    check("t2_early", bus.state, 3'd2);
    ticks(1);
    check("t2_play", bus.state, 3'd1);
    bus.btn = 2'b00;

    // T4: pause freezes play
    bus.pause_btn = 1'b1; step();
    check("t4_pause", bus.state, 3'd4);
    check("t4_still", bus.gra_still, 1'b1);
    bus.hit = 1'b1; repeat (2) step(); bus.hit = 1'b0;
    check("t4_hold", bus.state, 3'd4);
    check("t4_score", bus.score, 8'h03);
    bus.pause_btn = 1'b0; step();
    bus.miss = 1'b1; step(); bus.miss = 1'b0;
    check("t4_lives", bus.lives, 3'd2);
    check("t4_miss", bus.state, 3'd4);
    bus.pause_btn = 1'b1; step();
    check("t4_resume", bus.state, 3'd1);
    bus.pause_btn = 1'b0; step();

    // T3: BCD carry and saturation
    bus.hit = 1'b1;
    repeat (6) step();
    check("t3_09", bus.score, 8'h09);
    step();
    check("t3_10", bus.score, 8'h10);
    repeat (98) step();
    check("t3_sat", bus.score, 8'h99);
    bus.miss = 1'b1; bus.pause_btn = 1'b1; step();
    bus.hit = 1'b0; bus.miss = 1'b0;
    check("t3_sat_hm", bus.score, 8'h99);
    check("t3_lives", bus.lives, 3'd1);
    check("t3_prio", bus.state, 3'd2);
    bus.pause_btn = 1'b0; step();
    bus.btn = 2'b01; ticks(120); bus.btn = 2'b00;
    check("t3_play", bus.state, 3'd1);

    // T5: last ball lost, game over, return to NEWGAME
    bus.miss = 1'b1; step(); bus.miss = 1'b0;
    check("t5_over", bus.state, 3'd3);
    check("t5_lives0", bus.lives, 3'd0);
    check("t5_hi", bus.hiscore, {24'd0, hi_exp});
    bus.btn = 2'b11; ticks(119); bus.btn = 2'b00;
    check("t5_wait", bus.state, 3'd3);
    ticks(1);
    check("t5_newgame", bus.state, 3'd0);
    check("t5_lives3", bus.lives, 3'd3);
    check("t5_score0", bus.score, 8'h00);

    // Second game: hit+miss together, lower final score
    bus.btn = 2'b01; step(); bus.btn = 2'b00;
    bus.hit = 1'b1; bus.miss = 1'b1; step(); bus.hit = 1'b0; bus.miss = 1'b0;
    check("g2_score", bus.score, 8'h01);
    check("g2_lives", bus.lives, 3'd2);
    check("g2_state", bus.state, 3'd2);
    for (int i = 0; i < 2; i++) begin
      bus.btn = 2'b01; ticks(120); bus.btn = 2'b00;
      bus.miss = 1'b1; step(); bus.miss = 1'b0;
    end
    check("g2_over", bus.state, 3'd3);
    check("g2_score1", bus.score, 8'h01);
    check("g2_hi", bus.hiscore, {24'd0, hi_exp});

    // T6: asynchronous reset mid-timer in NEWBALL
    ticks(120);
    bus.btn = 2'b01; step(); bus.btn = 2'b00;
    bus.hit = 1'b1; step(); bus.hit = 1'b0;
    bus.miss = 1'b1; step(); bus.miss = 1'b0;
    check("t6_nb", bus.state, 3'd2);
    ticks(30);
    #2 reset = 1'b1;
    #1;
    check("t6_state", bus.state, 3'd0);
    check("t6_lives", bus.lives, 3'd3);
    check("t6_score", bus.score, 8'h00);
    check("t6_still", bus.gra_still, 1'b1);
    check("t6_hi", bus.hiscore, 8'h00);
    step();
    reset = 1'b0;
    step();
    bus.btn = 2'b10; step(); bus.btn = 2'b00;
    check("t6_restart", bus.state, 3'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
